// File: rtl/digit_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder_pkg
// Description : Shared definitions for the digit-serial adder/subtractor:
//               FSM state encoding and helpers that size the digit counter
//               and validate the WIDTH/DIGIT pairing.
// Optional    : DIGIT_SERIAL_ADDER_OVF_EN (used by the interface/top only)
// Revision    : 1.0 - initial release
// ============================================================================
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit cycles needed for one operation.
    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width; a single-digit operation still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Legal pairing: 1 <= DIGIT <= WIDTH and WIDTH a multiple of DIGIT.
    function automatic bit width_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage : digit_serial_adder_pkg
`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder_if
// Description : Request/response bundle for digit_serial_adder.
//               Request : in_valid, in_ready, a, b, cin, sub
//               Response: out_valid, out_ready, sum, cout, ovf (optional)
//               slave  modport = the adder, master modport = the requester.
// Optional    : DIGIT_SERIAL_ADDER_OVF_EN adds the ovf signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

endinterface : digit_serial_adder_if
`default_nettype wire

// File: rtl/digit_serial_adder_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : digit_add
// Description : Combinational DIGIT-bit ripple-carry adder.
//               a, b    : DIGIT-bit addends
//               cin     : carry into bit 0
//               sum     : DIGIT-bit result
//               cout    : carry out of the top bit
//               msb_cin : carry into the top bit (signed-overflow detection)
// Revision    : 1.0 - initial release
// ============================================================================
module digit_add #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic w_carry;

    // Ripple carry kept in a single procedural variable so the chain is
    // evaluated bit by bit without a combinational feedback vector.
    always_comb begin
        w_carry = cin;
        sum     = '0;
        msb_cin = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                msb_cin = w_carry;
            end
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule : digit_add
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder
// Description : Multi-cycle adder/subtractor processing DIGIT bits per clock
//               with a registered inter-digit carry, behind valid/ready
//               handshakes on request and response sides.
//               clk : rising-edge clock
//               rst : synchronous active-high reset
//               bus : digit_serial_adder_if.slave (request/response bundle)
// Optional    : DIGIT_SERIAL_ADDER_OVF_EN enables the signed overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_adder_if.slave  bus
);

    if (!width_ok(WIDTH, DIGIT)) begin : g_param_check
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
    end

    localparam int                 c_N     = calc_n(WIDTH, DIGIT);
    localparam int                 c_CNT_W = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_N - 1);

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 cout_q, cout_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic                 ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0]       w_dig_sum;
    logic                   w_dig_cout;
    logic                   w_msb_cin;
    logic [WIDTH+DIGIT-1:0] w_sum_cat;

    digit_add #(
        .DIGIT   (DIGIT)
    ) u_digit_add (
        .a       (a_q[DIGIT-1:0]),
        .b       (b_q[DIGIT-1:0]),
        .cin     (carry_q),
        .sum     (w_dig_sum),
        .cout    (w_dig_cout),
        .msb_cin (w_msb_cin)
    );

`ifndef DIGIT_SERIAL_ADDER_OVF_EN
    logic w_unused_msb_cin;
    assign w_unused_msb_cin = w_msb_cin;
`endif

    // New digit enters at the MSB end; slicing the concatenation keeps this
    // legal even when DIGIT == WIDTH (the old contents shift out entirely).
    assign w_sum_cat = {w_dig_sum, sum_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtract runs as a + ~b + ~cin through the same adder.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = w_sum_cat[WIDTH+DIGIT-1:DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = w_dig_cout;
                cnt_d   = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_LAST) begin
                    cout_d  = w_dig_cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                    ovf_d   = w_msb_cin ^ w_dig_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule : digit_serial_adder
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_serial_adder
// Description : Self-checking bench for digit_serial_adder. Main instance is
//               WIDTH=16/DIGIT=4 with a scoreboard queue and monitor; two
//               extra instances (DIGIT=1, DIGIT=16) check latency extremes.
// Optional    : DIGIT_SERIAL_ADDER_OVF_EN enables the ovf checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_err;
    bit   seen;
    exp_t q[$];

    digit_serial_adder_if #(.WIDTH(16)) bus   ();
    digit_serial_adder_if #(.WIDTH(16)) bus1  ();
    digit_serial_adder_if #(.WIDTH(16)) bus16 ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4))  u_dut     (.clk(clk), .rst(rst), .bus(bus));
    digit_serial_adder #(.WIDTH(16), .DIGIT(1))  u_dut_d1  (.clk(clk), .rst(rst), .bus(bus1));
    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t required < 300000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every cycle a result is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL spurious_out_valid: got out_valid 1 required 0 (no op pending)");
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", cyc - q[0].acc, 4);
                end
                check("sum", {16'h0, bus.sum}, {16'h0, q[0].sum});
                check("cout", {31'h0, bus.cout}, {31'h0, q[0].cout});
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                check("ovf", {31'h0, bus.ovf}, {31'h0, q[0].ovf});
`endif
                check("in_ready_in_done", {31'h0, bus.in_ready}, 32'h0);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                         input logic tsub, input logic [15:0] es, input logic ec,
                         input logic eo, input bit push);
        int w;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL issue_wait_in_ready: got in_ready 0 required 1 within 200 cycles");
        end
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tcin;
        bus.sub      = tsub;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        if (push) q.push_back('{sum: es, cout: ec, ovf: eo, acc: cyc});
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.cin      = 1'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || !bus.in_ready) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        int w;
        int acc;
        n_chk = 0;
        n_err = 0;
        seen  = 1'b0;
        rst   = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("reset_sum", {16'h0, bus.sum}, 32'h0);
        check("reset_cout", {31'h0, bus.cout}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic add, carry ripple, carry-in, subtract with/without borrow-in.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        // Signed overflow cases (ovf only compared when the feature is built).
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: result held, in_valid pulse ignored.
        bus.out_ready = 1'b0;
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("bp_out_valid_rises", {31'h0, bus.out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
            if (i == 1) begin
                bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_popped", q.size(), 0);
        check("bp_in_ready_after", {31'h0, bus.in_ready}, 32'h1);
        check("bp_out_valid_after", {31'h0, bus.out_valid}, 32'h0);

        // Reset mid-RUN: operation aborted, never reports.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("abort_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("abort_sum", {16'h0, bus.sum}, 32'h0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        drain();

        // DIGIT=1: latency 16.
        bus1.a = 16'h1234; bus1.b = 16'h4321; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        bus1.in_valid = 1'b0;
        w = 0;
        while (!bus1.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("d1_latency", cyc - acc, 16);
        check("d1_sum", {16'h0, bus1.sum}, 32'h5555);
        check("d1_cout", {31'h0, bus1.cout}, 32'h0);
        @(posedge clk); #1;

        // DIGIT=16: latency 1.
        bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        bus16.in_valid = 1'b0;
        w = 0;
        while (!bus16.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("d16_latency", cyc - acc, 1);
        check("d16_sum", {16'h0, bus16.sum}, 32'h5555);
        check("d16_cout", {31'h0, bus16.cout}, 32'h0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_digit_serial_adder
`default_nettype wire
